pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (F/D, D/E, E/M, M/W) for the RISC-V pipeline.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_stage_cell.sv | 35 +++
 rtl/pipe_stage_reg.sv | 92 +++++++++
 tb/tb_pipe_stage_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared D/E control-word layout and payload type for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned CTRL_DE_W      = 10;
  localparam int unsigned ALU_SRC_BIT    = 0;
  localparam int unsigned ALU_CTRL_LSB   = 1;
  localparam int unsigned ALU_CTRL_MSB   = 3;
  localparam int unsigned BRANCH_BIT     = 4;
  localparam int unsigned JUMP_BIT       = 5;
  localparam int unsigned MEM_WRITE_BIT  = 6;
  localparam int unsigned RESULT_SRC_LSB = 7;
  localparam int unsigned RESULT_SRC_MSB = 8;
  localparam int unsigned REG_WRITE_BIT  = 9;

  // Side-effecting fields that must never fire from a bubble.
  localparam logic [CTRL_DE_W-1:0] KILL_MASK_DE =
      (CTRL_DE_W'(1) << REG_WRITE_BIT) | (CTRL_DE_W'(1) << MEM_WRITE_BIT) |
      (CTRL_DE_W'(1) << JUMP_BIT)      | (CTRL_DE_W'(1) << BRANCH_BIT);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_de_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline register slice: valid/ctrl/data flops with stall hold, flush bubble and kill masking.
module pipe_stage_cell #(
  parameter int unsigned          CTRL_W    = 10,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [CTRL_W-1:0]    KILL_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              prev_valid,
  input  logic [CTRL_W-1:0] prev_ctrl,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Flush beats stall; a flushed slice keeps its payload but loses its side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= ctrl & ~KILL_MASK;
    end else if (!stall) begin
      valid <= prev_valid;
      ctrl  <= prev_valid ? prev_ctrl : (prev_ctrl & ~KILL_MASK);
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register of 1..4 slices with stall/flush.
// Optional stall/flush performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W    = CTRL_DE_W,
  parameter int unsigned       DATA_W    = $bits(word_t),
  parameter int unsigned       STAGES    = 1,
  parameter logic [CTRL_W-1:0] KILL_MASK = '0
`ifdef PIPE_PERF_EN
  , parameter int unsigned     CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES=%0d outside legal range 1..4", STAGES);
  end

  logic [STAGES-1:0]             slice_valid;
  logic [STAGES-1:0][CTRL_W-1:0] slice_ctrl;
  logic [STAGES-1:0][DATA_W-1:0] slice_data;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = valid_i;
      assign src_ctrl  = ctrl_i;
      assign src_data  = data_i;
    end else begin : g_body
      assign src_valid = slice_valid[k-1];
      assign src_ctrl  = slice_ctrl[k-1];
      assign src_data  = slice_data[k-1];
    end

    pipe_stage_cell #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .KILL_MASK (KILL_MASK)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall_i),
      .flush      (flush_i),
      .prev_valid (src_valid),
      .prev_ctrl  (src_ctrl),
      .prev_data  (src_data),
      .valid      (slice_valid[k]),
      .ctrl       (slice_ctrl[k]),
      .data       (slice_data[k])
    );
  end

  assign valid_o = slice_valid[STAGES-1];
  assign ctrl_o  = slice_ctrl[STAGES-1];
  assign data_o  = slice_data[STAGES-1];

`ifdef PIPE_PERF_EN
  // Saturating counters; a cycle with both stall and flush counts only as a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (flush_i && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
      if (stall_i && !flush_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised plus directed bench for pipe_stage_reg against a slot-array reference model.
// Two instances share stimulus: A (2 slices, mask 3C1) and B (3 slices, D/E kill mask).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned STG_A = 2;
  localparam int unsigned STG_B = 3;
  localparam logic [9:0]  MSK_A = 10'h3C1;
  localparam logic [9:0]  MSK_B = KILL_MASK_DE;
`ifdef PIPE_PERF_EN
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid;
  logic [9:0]  ctrl;
  logic [31:0] data;

  logic        valid_a, valid_b;
  logic [9:0]  ctrl_a, ctrl_b;
  logic [31:0] data_a, data_b;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(10), .DATA_W(32), .STAGES(STG_A), .KILL_MASK(MSK_A)
`ifdef PIPE_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .data_i(data),
`ifdef PIPE_PERF_EN
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a),
`endif
    .valid_o(valid_a), .ctrl_o(ctrl_a), .data_o(data_a)
  );

  pipe_stage_reg #(
    .CTRL_W(10), .DATA_W(32), .STAGES(STG_B), .KILL_MASK(MSK_B)
`ifdef PIPE_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut_b (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .data_i(data),
`ifdef PIPE_PERF_EN
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b),
`endif
    .valid_o(valid_b), .ctrl_o(ctrl_b), .data_o(data_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: each instance is an ordered array of slots, oldest at the highest index.
  logic        mv [2][4];
  logic [9:0]  mc [2][4];
  logic [31:0] md [2][4];
  int          m_stall_cnt, m_flush_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic int stg(input int i);
    return (i == 0) ? int'(STG_A) : int'(STG_B);
  endfunction

  function automatic logic [9:0] msk(input int i);
    return (i == 0) ? MSK_A : MSK_B;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        mv[i][k] = 1'b0; mc[i][k] = '0; md[i][k] = '0;
      end
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (flush) begin
        for (int k = 0; k < stg(i); k++) begin
          mv[i][k] = 1'b0;
          mc[i][k] = mc[i][k] & ~msk(i);
        end
      end else if (!stall) begin
        for (int k = stg(i) - 1; k > 0; k--) begin
          mv[i][k] = mv[i][k-1]; mc[i][k] = mc[i][k-1]; md[i][k] = md[i][k-1];
        end
        mv[i][0] = valid;
        mc[i][0] = valid ? ctrl : (ctrl & ~msk(i));
        md[i][0] = data;
      end
    end
`ifdef PIPE_PERF_EN
    if (flush) m_flush_cnt = (m_flush_cnt == int'(CNT_MAX)) ? m_flush_cnt : m_flush_cnt + 1;
    else if (stall) m_stall_cnt = (m_stall_cnt == int'(CNT_MAX)) ? m_stall_cnt : m_stall_cnt + 1;
`endif
  endtask

  task automatic compare_all(input string ph);
    check({ph, " valid_a"}, 64'(valid_a), 64'(mv[0][STG_A-1]));
    check({ph, " ctrl_a"},  64'(ctrl_a),  64'(mc[0][STG_A-1]));
    check({ph, " data_a"},  64'(data_a),  64'(md[0][STG_A-1]));
    check({ph, " valid_b"}, 64'(valid_b), 64'(mv[1][STG_B-1]));
    check({ph, " ctrl_b"},  64'(ctrl_b),  64'(mc[1][STG_B-1]));
    check({ph, " data_b"},  64'(data_b),  64'(md[1][STG_B-1]));
    if (!valid_a) check({ph, " inv_a"}, 64'(ctrl_a & MSK_A), 64'(0));
    if (!valid_b) check({ph, " inv_b"}, 64'(ctrl_b & MSK_B), 64'(0));
`ifdef PIPE_PERF_EN
    check({ph, " scnt_a"}, 64'(scnt_a), 64'(m_stall_cnt));
    check({ph, " fcnt_a"}, 64'(fcnt_a), 64'(m_flush_cnt));
    check({ph, " scnt_b"}, 64'(scnt_b), 64'(m_stall_cnt));
    check({ph, " fcnt_b"}, 64'(fcnt_b), 64'(m_flush_cnt));
`endif
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_step();
    #1;
    compare_all(ph);
  endtask

  // Async reset pulse placed between edges; outputs must clear without waiting for a clock.
  task automatic reset_pulse(input string ph);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all(ph);
    check({ph, " rst_valid_a"}, 64'(valid_a), 64'(0));
    check({ph, " rst_data_b"},  64'(data_b),  64'(0));
    #1 rst = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; valid = 1'b0; ctrl = '0; data = '0;
  endtask

  initial begin
    int hits, hit_edge;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Straight flow through two slices.
    valid = 1'b1; ctrl = 10'h3A5; data = 32'hDEAD_BEEF;
    step("flow");
    valid = 1'b0; ctrl = '0; data = '0;
    step("flow");
    check("flow valid", 64'(valid_a), 64'(1));
    check("flow ctrl",  64'(ctrl_a),  64'h3A5);
    check("flow data",  64'(data_a),  64'hDEAD_BEEF);
    step("flow");
    step("flow");

    // Three stall cycles with one item in flight: exits at edge 5, exactly once.
    valid = 1'b1; ctrl = 10'h155; data = 32'hCAFE_0001;
    step("stall");
    valid = 1'b0; ctrl = '0; data = '0;
    hits = 0; hit_edge = 0;
    for (int e = 2; e <= 9; e++) begin
      stall = (e <= 4);
      step("stall");
      if (valid_a && data_a == 32'hCAFE_0001) begin
        hits++;
        hit_edge = e;
      end
    end
    stall = 1'b0;
    check("stall hits", 64'(hits), 64'(1));
    check("stall edge", 64'(hit_edge), 64'(5));

    // Stall followed by stall+flush on a held all-ones control word.
    valid = 1'b1; ctrl = 10'h3FF; data = 32'h1234_5678;
    step("sflush");
    valid = 1'b0; ctrl = '0; data = '0;
    step("sflush");
    stall = 1'b1;
    step("sflush");
    flush = 1'b1;
    step("sflush");
    check("sflush valid", 64'(valid_a), 64'(0));
    check("sflush ctrl",  64'(ctrl_a),  64'h03E);
    check("sflush data",  64'(data_a),  64'h1234_5678);
    idle_inputs();
    step("sflush");

    // Invalid input with every control bit set must come out with the kill bits cleared.
    valid = 1'b0; ctrl = 10'h3FF; data = 32'hA5A5_0F0F;
    for (int e = 0; e < 3; e++) step("bubble");
    check("bubble valid", 64'(valid_b), 64'(0));
    check("bubble kill",  64'(ctrl_b & KILL_MASK_DE), 64'(0));
    check("bubble ctrl",  64'(ctrl_b), 64'h18F);
    idle_inputs();

    // Reset with slices full.
    valid = 1'b1; ctrl = 10'h2AB; data = 32'h0BAD_F00D;
    for (int e = 0; e < 3; e++) step("full");
    reset_pulse("midrst");

`ifdef PIPE_PERF_EN
    idle_inputs();
    stall = 1'b1;
    for (int e = 0; e < 20; e++) step("perf");
    check("perf stall sat", 64'(scnt_a), 64'hF);
    stall = 1'b0; flush = 1'b1;
    for (int e = 0; e < 2; e++) step("perf");
    check("perf flush cnt", 64'(fcnt_a), 64'(2));
    idle_inputs();
    reset_pulse("perfrst");
    check("perf rst scnt", 64'(scnt_b), 64'(0));
`endif

    // Random traffic with occasional asynchronous resets, including during stalls.
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 11) == 0);
      valid = 1'($urandom_range(0, 1));
      ctrl  = 10'($urandom);
      data  = $urandom;
      step("rand");
      if ($urandom_range(0, 49) == 0) reset_pulse("randrst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
